regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port scalar register file; successor to the fixed 32x32, 2-read/1-write scalar register file in the CGRA datapath.
- Adds configurable width, depth and read-port count, and registered reads with a valid strobe.
- Adds a per-entry pending scoreboard so the CGRA sequencer can detect read-after-write hazards on in-flight results.
- Optional hardwired-zero entry 0.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 32, number of entries; any value ≥2, not required to be a power of 2.
- NRD, 2, number of read ports.
- ZERO_R0, 0, when 1: entry 0 reads as zero, ignores writes and never becomes pending.
- AW (localparam), $clog2(DEPTH), address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- we  in  1  write enable.
- wr  in  AW  write address.
- wd  in  WIDTH  write data.
- rd_en  in  NRD  per-port read enable.
- rr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW].
- dr  out  NRD*WIDTH  read data; port i at bits [i*WIDTH +: WIDTH].
- rd_valid  out  NRD  per-port read-data valid.
- rd_busy  out  NRD  per-port: the entry read was pending when sampled.
- rsv  in  1  reserve request: mark entry rsv_addr pending.
- rsv_addr  in  AW  entry to reserve.
- pend  out  DEPTH  pending bit vector, registered.

Behaviour:
- Reset (rst_n=0 at a clock edge): all entries 0; dr 0; rd_valid 0; rd_busy 0; pend 0. Reset has priority over every other input. Reset during a read discards that read: rd_valid is 0 the next cycle.
- Write: at an edge with we=1 and wr<DEPTH, mem[wr] <= wd.
  - wr≥DEPTH: write ignored, no state change.
  - ZERO_R0=1 and wr=0: write ignored.
- Read: 1-cycle latency. At an edge with rd_en[i]=1, the following are registered together:
  - dr[i] <= mem[rr[i]];
  - rd_busy[i] <= pend[rr[i]];
  - rd_valid[i] <= 1.
- With rd_en[i]=0: rd_valid[i] <= 0; dr[i] and rd_busy[i] hold their last values.
- Read address ≥DEPTH: dr[i]=0, rd_busy[i]=0, rd_valid[i]=1.
- ZERO_R0=1 and rr[i]=0: dr[i]=0, rd_busy[i]=0.
- Multiple ports reading the same address: all return the same value, no conflict.
- Read/write same address, same edge: the read returns the pre-write value. The exception is with REGFILE_BYPASS_EN defined; see Optional Feature.
- Scoreboard:
  - rsv=1 sets pend[rsv_addr] at the edge.
  - A write with we=1 clears pend[wr] at the edge.
  - Write and rsv to the same address on the same edge: the write lands and pend stays 1. The reservation belongs to a new producer.
  - rsv to an already-pending entry: no change.
  - Write to a non-pending entry: pend stays 0.
  - rsv_addr≥DEPTH: ignored.
  - ZERO_R0=1: pend[0] is constantly 0.
- rd_busy samples pend before that edge's updates. The exception is with REGFILE_BYPASS_EN defined; see Optional Feature.
- No internal state machine beyond the storage, pend and output registers. No stalls; every input is accepted every cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read and a write to the same valid, non-zero-hardwired address on the same edge forward wd, so dr[i]=wd the next cycle.
  - rd_busy[i] reflects pend after the write clear; a simultaneous rsv to that address still yields 1.
- Undefined: the read returns the old contents, and rd_busy reflects pend before the edge.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then rd_en=2'b11, rr={12,8} → next cycle: dr=0 on both ports, rd_valid=2'b11, rd_busy=0, pend=0.
- Write wr=8, wd=123, then wr=12, wd=321; next cycle rd_en=2'b11, rr port0=8, port1=12 → one cycle later: dr port0=123, port1=321, rd_valid=11.
- rsv=1, rsv_addr=5; next cycle read 5 → rd_busy=1, pend[5]=1. Then write wr=5, wd=77 → pend[5]=0; a later read of 5 gives dr=77, rd_busy=0.
- Same-edge write wr=3, wd=0xAA (old value 0x11) and read rr=3:
  - without macro → dr=0x11, rd_busy=0;
  - with REGFILE_BYPASS_EN → dr=0xAA.
  - Same-edge rsv and write to address 9 → pend[9]=1 afterwards.
- ZERO_R0=1: write wr=0, wd=55, rsv_addr=0, then read 0 → dr=0, rd_busy=0, pend[0]=0.
- DEPTH=20: write wr=25 is ignored (no entry changes); a read of 25 gives dr=0, rd_valid=1. Asserting rst_n=0 on the cycle after rd_en → rd_valid=0 and all entries are 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: registered reads with valid/busy strobes and a per-entry pending scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-edge write data to reads of the written entry.
module regfile_mp #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        wr,
  input  logic [WIDTH-1:0]     wd,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rr,
  output logic [NRD*WIDTH-1:0] dr,
  output logic [NRD-1:0]       rd_valid,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 rsv,
  input  logic [AW-1:0]        rsv_addr,
  output logic [DEPTH-1:0]     pend
);

  localparam bit ZR = (ZERO_R0 != 0);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]     pend_n;
  logic [NRD*WIDTH-1:0] dr_n;
  logic [NRD-1:0]       busy_n;
  logic [AW-1:0]        ra [NRD];
  logic                 wr_ok;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  function automatic logic hardwired(input logic [AW-1:0] a);
    return ZR && (a == '0);
  endfunction

  assign wr_ok = we && in_range(wr) && !hardwired(wr);

  // Reservation is applied after the write clear so a new producer wins.
  always_comb begin
    pend_n = pend;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (we && 32'(wr) == j)
        pend_n[j] = 1'b0;
      if (rsv && 32'(rsv_addr) == j && !(ZR && j == 0))
        pend_n[j] = 1'b1;
    end
  end

  always_comb begin
    dr_n   = '0;
    busy_n = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      ra[i] = rr[i*AW +: AW];
      if (!in_range(ra[i]) || hardwired(ra[i])) begin
        dr_n[i*WIDTH +: WIDTH] = '0;
        busy_n[i]              = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (wr_ok && wr == ra[i]) begin
        dr_n[i*WIDTH +: WIDTH] = wd;
        busy_n[i]              = rsv && (rsv_addr == ra[i]);
      end
`endif
      else begin
        dr_n[i*WIDTH +: WIDTH] = mem[ra[i]];
        busy_n[i]              = pend[ra[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem      <= '{default: '0};
      pend     <= '0;
      dr       <= '0;
      rd_valid <= '0;
      rd_busy  <= '0;
    end else begin
      if (wr_ok)
        mem[wr] <= wd;
      pend     <= pend_n;
      rd_valid <= rd_en;
      for (int unsigned i = 0; i < NRD; i++) begin
        if (rd_en[i]) begin
          dr[i*WIDTH +: WIDTH] <= dr_n[i*WIDTH +: WIDTH];
          rd_busy[i]           <= busy_n[i];
        end
      end
    end
  end

endmodule
